lampfpu_exp_arb: RTL and testbench

LAMPFPU_EXP_ARB -- requirements
Module: lampfpu_exp_arb

---
 rtl/lampfpu_exp_arb.sv | 184 ++++++++++++++++++
 tb/tb_lampfpu_exp_arb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lampfpu_exp_arb.sv
// lampfpu_exp_arb: shares one lampFPU multiplier among NUM_REQ requesters.
// One multiply is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Optional feature: define LAMPFPU_EXP_ARB_RR_EN for round-robin arbitration;
// otherwise the lowest-index requester always wins.
//
// Handshakes: a request moves when req_valid_i[k] && req_ready_o[k] at a rising
// edge (req_ready_o is one-hot and only in IDLE); a response moves when
// rsp_valid_o[g] && rsp_ready_i[g]; rsp_valid_o/rsp_result_o hold until taken.

package lampfpu_exp_arb_pkg;
    typedef enum logic [3:0] {
        FPU_IDLE = 4'd0, FPU_I2F, FPU_F2I, FPU_ADD, FPU_SUB,
        FPU_MUL, FPU_DIV, FPU_EQ, FPU_LT, FPU_LE
    } opcodeFPU_t;

    typedef enum logic [2:0] {
        FPU_RNDMODE_NEAREST = 3'd0, FPU_RNDMODE_TRUNCATE,
        FPU_RNDMODE_PLUS_INF, FPU_RNDMODE_MINUS_INF
    } rndModeFPU_t;
endpackage

module lampfpu_exp_arb
    import lampfpu_exp_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req_valid_i,
    output logic [NUM_REQ-1:0]                       req_ready_o,
    input  logic [NUM_REQ*DW-1:0]                    req_op1_i,
    input  logic [NUM_REQ*DW-1:0]                    req_op2_i,
    input  logic [NUM_REQ*$bits(rndModeFPU_t)-1:0]   req_rndMode_i,
    output logic [NUM_REQ-1:0]                       rsp_valid_o,
    output logic [DW-1:0]                            rsp_result_o,
    input  logic [NUM_REQ-1:0]                       rsp_ready_i,
    output opcodeFPU_t                               fpu_opcode_o,
    output rndModeFPU_t                              fpu_rndMode_o,
    output logic [DW-1:0]                            fpu_op1_o,
    output logic [DW-1:0]                            fpu_op2_o,
    output logic                                     fpu_flush_o,
    output logic                                     fpu_padv_o,
    input  logic [DW-1:0]                            fpu_result_i,
    input  logic                                     fpu_isResultValid_i,
    input  logic                                     fpu_isReady_i
);

    localparam int RW = $bits(rndModeFPU_t);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q;
    logic [DW-1:0]   op1_q, op2_q, res_q;
    rndModeFPU_t     rnd_q;
    logic [GW-1:0]   sel;
    logic [GW-1:0]   idx;
    logic            found;
    logic            load;
    logic            capture;
    logic            fpu_ready_unused;

    // The FPU readiness flag is observed only by external monitors.
    assign fpu_ready_unused = fpu_isReady_i;

`ifdef LAMPFPU_EXP_ARB_RR_EN
    logic [GW-1:0]   ptr_q;
    logic [GW:0]     sum;

    // Round-robin pick: first valid requester at or after ptr_q, wrapping.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + (GW+1)'(i);
            if (sum >= (GW+1)'(NUM_REQ)) sum = sum - (GW+1)'(NUM_REQ);
            idx = sum[GW-1:0];
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end
`else
    // Fixed priority pick: lowest-index valid requester wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = GW'(i);
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end
`endif

    // Next-state and outputs; everything is forced quiet while rst is high.
    always_comb begin
        state_d      = state_q;
        req_ready_o  = '0;
        rsp_valid_o  = '0;
        rsp_result_o = '0;
        fpu_opcode_o = FPU_IDLE;
        fpu_padv_o   = 1'b0;
        load         = 1'b0;
        capture      = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        req_ready_o[sel] = 1'b1;
                        load             = 1'b1;
                        state_d          = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    fpu_opcode_o = FPU_MUL;
                    state_d      = S_WAIT;
                end
                S_WAIT: begin
                    // padv advances the FPU pipeline on the result cycle only.
                    if (fpu_isResultValid_i) begin
                        fpu_padv_o = 1'b1;
                        capture    = 1'b1;
                        state_d    = S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid_o[grant_q] = 1'b1;
                    rsp_result_o         = res_q;
                    if (rsp_ready_i[grant_q]) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Operands are driven from registers so the FPU sees them stable while it
    // re-samples them each cycle of the operation.
    assign fpu_op1_o     = rst ? '0 : op1_q;
    assign fpu_op2_o     = rst ? '0 : op2_q;
    assign fpu_rndMode_o = rst ? FPU_RNDMODE_NEAREST : rnd_q;
    assign fpu_flush_o   = 1'b0;

    // State, grant, operand and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            rnd_q   <= FPU_RNDMODE_NEAREST;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                grant_q <= sel;
                op1_q   <= req_op1_i[int'(sel)*DW +: DW];
                op2_q   <= req_op2_i[int'(sel)*DW +: DW];
                rnd_q   <= rndModeFPU_t'(req_rndMode_i[int'(sel)*RW +: RW]);
            end
            if (capture) res_q <= fpu_result_i;
        end
    end

`ifdef LAMPFPU_EXP_ARB_RR_EN
    // Round-robin pointer moves just past the requester that was granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (load) begin
            ptr_q <= (sel == GW'(NUM_REQ-1)) ? '0 : sel + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lampfpu_exp_arb.sv
// Directed testbench for lampfpu_exp_arb with a small behavioural FPU responder.
module tb_lampfpu_exp_arb;
    import lampfpu_exp_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DW      = 16;
    localparam int RW      = $bits(rndModeFPU_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]      req_valid_i = '0;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic [NUM_REQ*DW-1:0]   req_op1_i = '0;
    logic [NUM_REQ*DW-1:0]   req_op2_i = '0;
    logic [NUM_REQ*RW-1:0]   req_rndMode_i = '0;
    logic [NUM_REQ-1:0]      rsp_valid_o;
    logic [DW-1:0]           rsp_result_o;
    logic [NUM_REQ-1:0]      rsp_ready_i = '1;
    opcodeFPU_t              fpu_opcode_o;
    rndModeFPU_t             fpu_rndMode_o;
    logic [DW-1:0]           fpu_op1_o;
    logic [DW-1:0]           fpu_op2_o;
    logic                    fpu_flush_o;
    logic                    fpu_padv_o;
    logic [DW-1:0]           fpu_result_i = '0;
    logic                    fpu_isResultValid_i = 1'b0;
    logic                    fpu_isReady_i = 1'b1;

    lampfpu_exp_arb #(.NUM_REQ(NUM_REQ), .DW(DW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_op1_i           (req_op1_i),
        .req_op2_i           (req_op2_i),
        .req_rndMode_i       (req_rndMode_i),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_result_o        (rsp_result_o),
        .rsp_ready_i         (rsp_ready_i),
        .fpu_opcode_o        (fpu_opcode_o),
        .fpu_rndMode_o       (fpu_rndMode_o),
        .fpu_op1_o           (fpu_op1_o),
        .fpu_op2_o           (fpu_op2_o),
        .fpu_flush_o         (fpu_flush_o),
        .fpu_padv_o          (fpu_padv_o),
        .fpu_result_i        (fpu_result_i),
        .fpu_isResultValid_i (fpu_isResultValid_i),
        .fpu_isReady_i       (fpu_isReady_i)
    );

    // ---------------- FPU responder ----------------
    // Pulses isResultValid fpu_work cycles after it sees FPU_MUL.
    int          fpu_work    = 1;
    logic [15:0] fpu_res_val = '0;
    int          fpu_cnt     = 0;

    always @(posedge clk) begin
        if (rst) begin
            fpu_cnt             <= 0;
            fpu_isResultValid_i <= 1'b0;
            fpu_result_i        <= '0;
        end else begin
            fpu_isResultValid_i <= 1'b0;
            if (fpu_opcode_o == FPU_MUL) begin
                fpu_cnt <= fpu_work;
            end else if (fpu_cnt != 0) begin
                fpu_cnt <= fpu_cnt - 1;
                if (fpu_cnt == 1) begin
                    fpu_isResultValid_i <= 1'b1;
                    fpu_result_i        <= fpu_res_val;
                end
            end
        end
    end

    // ---------------- FPU-side monitor ----------------
    int          mul_total  = 0;
    int          padv_total = 0;
    int          padv_bad   = 0;
    int          hold_bad   = 0;
    logic [15:0] mon_op1    = '0;
    logic [15:0] mon_op2    = '0;
    logic [2:0]  mon_rnd    = '0;
    bit          in_flight  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            in_flight = 1'b0;
        end else begin
            if (fpu_padv_o != fpu_isResultValid_i) padv_bad++;
            if (fpu_padv_o) padv_total++;
            if (fpu_opcode_o == FPU_MUL) begin
                mul_total++;
                mon_op1   = fpu_op1_o;
                mon_op2   = fpu_op2_o;
                mon_rnd   = fpu_rndMode_o;
                in_flight = 1'b1;
            end else if (in_flight) begin
                if (fpu_op1_o != mon_op1 || fpu_op2_o != mon_op2 ||
                    fpu_rndMode_o != mon_rnd) hold_bad++;
                if (fpu_padv_o) in_flight = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [NUM_REQ-1:0] v);
        idx_of = -1;
        for (int i = NUM_REQ-1; i >= 0; i--) if (v[i]) idx_of = i;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] rm);
        req_op1_i[r*DW +: DW]     = a;
        req_op2_i[r*DW +: DW]     = b;
        req_rndMode_i[r*RW +: RW] = rm;
    endtask

    // Called just after a negedge (#1 settled); waits for any req_ready_o.
    task automatic wait_ready();
        for (int n = 0; n < 60; n++) begin
            if (req_ready_o != '0) break;
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid_o == '0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_txn(input int r, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] rm, input logic [15:0] res,
                           input int work, input bit bp);
        int m0, p0, pb0, h0, lat, other;
        bit ok;
        fpu_work    = work;
        fpu_res_val = res;
        m0 = mul_total; p0 = padv_total; pb0 = padv_bad; h0 = hold_bad;
        @(negedge clk);
        set_req(r, a, b, rm);
        rsp_ready_i = '1;
        if (bp) rsp_ready_i[r] = 1'b0;
        req_valid_i[r] = 1'b1;
        #1;
        wait_ready();
        check($sformatf("ready_onehot_r%0d", r), req_ready_o, 32'(1 << r));
        @(negedge clk);
        req_valid_i[r] = 1'b0;
        wait_rsp(lat);
        check($sformatf("latency_r%0d", r), lat, 3 + work);
        check($sformatf("rsp_valid_r%0d", r), rsp_valid_o, 32'(1 << r));
        check($sformatf("rsp_result_r%0d", r), rsp_result_o, res);
        check($sformatf("fpu_op1_r%0d", r), mon_op1, a);
        check($sformatf("fpu_op2_r%0d", r), mon_op2, b);
        check($sformatf("fpu_rnd_r%0d", r), mon_rnd, rm);
        check($sformatf("mul_cycles_r%0d", r), mul_total - m0, 1);
        check($sformatf("padv_pulses_r%0d", r), padv_total - p0, 1);
        check($sformatf("padv_align_r%0d", r), padv_bad - pb0, 0);
        check($sformatf("op_hold_r%0d", r), hold_bad - h0, 0);
        if (bp) begin
            ok    = 1'b1;
            other = (r + 1) % NUM_REQ;
            req_valid_i[other] = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk); #1;
                if (rsp_valid_o != NUM_REQ'(1 << r) || rsp_result_o != res ||
                    req_ready_o != '0 || fpu_opcode_o != FPU_IDLE) ok = 1'b0;
            end
            check($sformatf("bp_stable_r%0d", r), ok, 1);
            req_valid_i[other] = 1'b0;
            rsp_ready_i[r]     = 1'b1;
        end
        @(negedge clk);
        check($sformatf("rsp_clear_valid_r%0d", r), rsp_valid_o, 0);
        check($sformatf("rsp_clear_result_r%0d", r), rsp_result_o, 0);
        check($sformatf("flush_r%0d", r), fpu_flush_o, 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_handshake"}, {req_ready_o, rsp_valid_o, fpu_padv_o, fpu_flush_o}, 0);
        check({tag, "_result"}, rsp_result_o, 0);
        check({tag, "_fpu_ctl"}, {fpu_opcode_o, fpu_rndMode_o}, {FPU_IDLE, FPU_RNDMODE_NEAREST});
        check({tag, "_fpu_ops"}, {fpu_op1_o, fpu_op2_o}, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int exp_g[5];
        int g, lat;
`ifdef LAMPFPU_EXP_ARB_RR_EN
        exp_g = '{0, 1, 2, 3, 0};
`else
        exp_g = '{0, 0, 0, 0, 0};
`endif
        repeat (3) @(negedge clk);
        check_quiet("in_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("idle_no_req");

        // Contention: all requesters held valid.
        fpu_work    = 1;
        fpu_res_val = 16'h1234;
        for (int k = 0; k < NUM_REQ; k++) set_req(k, 16'h3F80 + 16'(k), 16'h4000, 3'd0);
        @(negedge clk);
        req_valid_i = '1;
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_ready();
            g = idx_of(req_ready_o);
            check($sformatf("contention_grant%0d", k), g, exp_g[k]);
            @(negedge clk); #1;
        end
        req_valid_i = '0;
        wait_rsp(lat);
        check("contention_last_rsp", rsp_result_o, 16'h1234);
        @(negedge clk);

        // Directed multiplies: hand-computed bfloat16 products.
        run_txn(1, 16'h3FC0, 16'h3FC0, FPU_RNDMODE_NEAREST,   16'h4010, 1, 0); // 1.5*1.5
        run_txn(0, 16'h4040, 16'hC000, FPU_RNDMODE_NEAREST,   16'hC0C0, 3, 0); // 3*-2
        run_txn(2, 16'h3F80, 16'h4000, FPU_RNDMODE_TRUNCATE,  16'h4000, 2, 1); // backpressure
        run_txn(3, 16'h7F80, 16'h0000, FPU_RNDMODE_NEAREST,   16'h7FC0, 2, 0); // inf*0 -> NaN
        run_txn(0, 16'h3F80, 16'h3F80, FPU_RNDMODE_PLUS_INF,  16'h3F80, 4, 0); // 1*1

        // Reset in the middle of WAIT.
        fpu_work    = 6;
        fpu_res_val = 16'hDEAD;
        @(negedge clk);
        set_req(2, 16'h4100, 16'h4100, FPU_RNDMODE_MINUS_INF);
        req_valid_i[2] = 1'b1;
        #1;
        wait_ready();
        check("midwait_grant", idx_of(req_ready_o), 2);
        @(negedge clk);
        req_valid_i[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("midwait_reset");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("after_reset");

        // After reset the arbiter must start searching from requester 0 again.
        fpu_work    = 1;
        fpu_res_val = 16'h3F00;
        set_req(1, 16'h3F80, 16'h3F00, FPU_RNDMODE_NEAREST);
        set_req(3, 16'h4000, 16'h4000, FPU_RNDMODE_NEAREST);
        req_valid_i[1] = 1'b1;
        req_valid_i[3] = 1'b1;
        #1;
        wait_ready();
        check("post_reset_grant", idx_of(req_ready_o), 1);
        @(negedge clk);
        req_valid_i = '0;
        wait_rsp(lat);
        check("post_reset_rsp_valid", rsp_valid_o, 4'b0010);
        check("post_reset_rsp_result", rsp_result_o, 16'h3F00);
        @(negedge clk);

        run_txn(3, 16'h4000, 16'h4000, FPU_RNDMODE_MINUS_INF, 16'h4080, 1, 0); // 2*2

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case a sequence never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
